// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   - Default parameter values for pattern width, repeat-count width and
//     the idle gap inserted between repetitions.
//   - FSM state encoding used by seq_pattern_gen.
package seq_gen_pkg;

   localparam int PAT_W_DEF   = 8;  // maximum pattern length in bits
   localparam int RPT_W_DEF   = 4;  // repeat-count width
   localparam int GAP_CYC_DEF = 2;  // idle cycles between repetitions

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage : seq_gen_pkg

// File: rtl/seq_shift_reg.sv
// Pattern shadow register and bit index for the pattern generator.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - capture pattern_in/len_in, point index at bit len_in-1
//   pattern_in  - pattern to capture
//   len_in      - pattern length to capture (already range-checked)
//   shift       - step index down by one
//   reload      - point index back at bit len-1 of the captured length
//   last        - index currently at bit 0
//   next_bit    - bit that will be current after this clock edge; lets
//                 the parent register data_out with no added latency
module seq_shift_reg
   import seq_gen_pkg::*;
#(
   parameter  int PAT_W = PAT_W_DEF,
   localparam int LEN_W = $clog2(PAT_W) + 1,
   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             shift,
   input  logic             reload,
   output logic             last,
   output logic             next_bit
);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      pat_d = pat_q;
      len_d = len_q;
      idx_d = idx_q;
      if (load) begin
         pat_d = pattern_in;
         len_d = len_in;
         idx_d = IDX_W'(len_in - LEN_W'(1));
      end else if (reload) begin
         // Restart from the top of the captured length, never from the
         // top of the physical register.
         idx_d = IDX_W'(len_q - LEN_W'(1));
      end else if (shift) begin
         idx_d = idx_q - IDX_W'(1);
      end
      next_bit = pat_d[idx_d];
      last     = (idx_q == '0);
   end

   // NOTE: the shadow registers are small flops, not a RAM, so they are
   // cleared by reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all
         // flops update together from pre-edge values.
         pat_q <= '0;
         len_q <= '0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         len_q <= len_d;
         idx_q <= idx_d;
      end
   end

endmodule : seq_shift_reg

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends pattern[len-1:0] MSB-first, repeat_n
// times (0 = until abort), with GAP_CYC idle cycles between repetitions.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request a transmission (sampled only in IDLE)
//   pattern     - bits to send
//   len         - number of bits to send, legal 1..PAT_W
//   repeat_n    - repetitions, 0 = continuous
//   abort       - end an active transmission at the next edge
//   data_out    - serial bit stream (0 when not valid)
//   data_valid  - data_out carries a pattern bit this cycle
//   busy        - block is not in IDLE
//   done        - one-cycle pulse on normal completion
// All outputs are flops loaded from next-state values, so the first bit
// is visible in the cycle right after the accepting edge.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter  int PAT_W   = PAT_W_DEF,
   parameter  int RPT_W   = RPT_W_DEF,
   parameter  int GAP_CYC = GAP_CYC_DEF,
   localparam int LEN_W   = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [RPT_W-1:0] repeat_n,
   input  logic             abort,
   output logic             data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             done
);

   localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   state_e           state_q, state_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic len_ok;
   logic rpt_more;
   logic sr_load, sr_shift, sr_reload;
   logic sr_last, sr_next_bit;

   seq_shift_reg #(.PAT_W(PAT_W)) u_shift_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (sr_load),
      .pattern_in (pattern),
      .len_in     (len),
      .shift      (sr_shift),
      .reload     (sr_reload),
      .last       (sr_last),
      .next_bit   (sr_next_bit)
   );

   assign len_ok = (len != '0) && (len <= LEN_W'(PAT_W));
   // Another repetition follows if running continuously (count 0) or if
   // more than the current repetition is still owed.
   assign rpt_more = (rpt_q == '0) || (rpt_q > RPT_W'(1));

   always_comb begin
      state_d   = state_q;
      rpt_d     = rpt_q;
      gap_d     = gap_q;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      sr_reload = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && len_ok) begin
               state_d = ST_SHIFT;
               sr_load = 1'b1;
               rpt_d   = repeat_n;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!sr_last) begin
               sr_shift = 1'b1;
            end else begin
               // Saturating decrement: continuous mode stays at 0.
               if (rpt_q != '0) rpt_d = rpt_q - RPT_W'(1);
               if (rpt_more) begin
                  sr_reload = 1'b1;
                  if (GAP_CYC > 0) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_W'(GAP_LOAD);
                  end
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_q == '0) begin
               state_d = ST_SHIFT;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      data_valid_d = (state_d == ST_SHIFT);
      data_out_d   = data_valid_d & sr_next_bit;
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rpt_q        <= '0;
         gap_q        <= '0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rpt_q        <= rpt_d;
         gap_q        <= gap_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule : seq_pattern_gen

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 Parameter RPT_W, default 4: width of the repeat-count input.
REQ-003 Parameter GAP_CYC, default 2: idle cycles inserted between repetitions; 0 SHALL be legal.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request a transmission; sampled only in IDLE.
REQ-007 pattern  in  PAT_W  bits to send, transmitted MSB-first from pattern[len-1] down to pattern[0].
REQ-008 len  in  $clog2(PAT_W)+1  number of pattern bits, with legal range 1..PAT_W.
REQ-009 repeat_n  in  RPT_W  number of repetitions; 0 = continuous until abort.
REQ-010 abort  in  1  terminate an active transmission.
REQ-011 data_out  out  1  serial bit stream, suitable to drive a sequence detector's data_in.
REQ-012 data_valid  out  1  high in every cycle in which data_out carries a pattern bit.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-016 IDLE: start=1 with 1<=len<=PAT_W SHALL, at that edge, capture pattern/len/repeat_n into shadow registers and enter SHIFT.
- The first bit SHALL appear on data_out with data_valid=1 in the next cycle (latency 1).
REQ-017 start with len=0 or len>PAT_W SHALL be ignored: the block stays in IDLE with no output activity.
REQ-018 SHIFT: one bit per cycle; each bit SHALL be held exactly one cycle, giving len consecutive valid cycles per repetition.
REQ-019 After the last bit of a repetition, if further repetitions remain:
- GAP_CYC>0: enter GAP for exactly GAP_CYC cycles with data_out=0 and data_valid=0, then resume SHIFT from bit len-1.
- GAP_CYC=0: the first bit of the next repetition SHALL follow back-to-back with no invalid cycle.
REQ-020 After the final repetition the FSM SHALL enter DONE for one cycle with done=1, busy=1 and data_valid=0, then return to IDLE.
REQ-021 repeat_n=0 SHALL repeat indefinitely, never asserting done; only abort or reset ends it.
REQ-022 abort=1 in SHIFT/GAP SHALL force IDLE at the next edge with data_valid=0 and busy=0, and SHALL NOT pulse done.
REQ-023 abort takes priority over every other transition; abort in IDLE or DONE SHALL have no effect beyond the normal DONE->IDLE step.
REQ-024 start while busy, and changes to pattern/len/repeat_n while busy, SHALL be ignored; only the shadow copies are used.
REQ-025 The repetition counter SHALL decrement once per completed repetition and SHALL saturate at 0 without wrap.
REQ-026 The bit index SHALL count from len-1 to 0 and SHALL reload to len-1 without wrap into unused pattern bits.
REQ-027 data_out SHALL be 0 whenever data_valid=0.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with data_out=0, data_valid=0, busy=0, done=0, and counters and shadow registers cleared, independent of clk.
REQ-029 Reset asserted mid-transmission SHALL abandon that transmission; after release the block SHALL accept start on the first clk edge.

Structure
REQ-030 A shared package seq_gen_pkg SHALL hold the state enum and the default values of PAT_W, RPT_W and GAP_CYC.
REQ-031 The pattern shadow register and bit index SHALL live in one sub-module, seq_shift_reg (load, shift, reload, current bit), instantiated once.

Verification
REQ-032 pattern=8'b0000_0110, len=4, repeat_n=1, GAP_CYC=2: data_out 0,1,1,0 with data_valid high for 4 cycles, then done high in the 5th cycle; a 0110 detector fed this stream fires once.
REQ-033 Same pattern, repeat_n=3, GAP_CYC=0: 12 contiguous valid bits 011001100110, then a single done pulse.
REQ-034 repeat_n=2, GAP_CYC=2: 4 valid, 2 invalid (data_out=0), 4 valid, then done.
REQ-035 abort on the 2nd valid bit: at the next edge data_valid=0 and busy=0, and done is never asserted.
REQ-036 start with len=0, and start while busy: no state change; output matches the original transmission exactly.
REQ-037 rst_n driven low between clock edges during SHIFT: outputs clear immediately; a fresh start after release gives the REQ-032 waveform.
